regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised successor to the single-write-port 32x32 register file in the CA2 datapath.
- Generalised data width and register count; two write ports (W0 = ALU writeback, W1 = memory/load writeback); two combinational read ports.
- Adds reset clearing of all registers, a per-register busy scoreboard for hazard detection, and optional write-to-read bypass.
- Sits between decode (reads, busy check, issue) and writeback (W0/W1).

Parameters:
- DATA_W, 32, register data width in bits.
- NREGS, 32, number of registers; power of two, minimum 2.
- ADDR_W, $clog2(NREGS), register address width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ra1  in  ADDR_W  read port 1 address
- ra2  in  ADDR_W  read port 2 address
- rd1  out  DATA_W  read port 1 data
- rd2  out  DATA_W  read port 2 data
- busy1  out  1  register at ra1 has a pending write
- busy2  out  1  register at ra2 has a pending write
- we0  in  1  write enable, port W0
- wa0  in  ADDR_W  write address, port W0
- wd0  in  DATA_W  write data, port W0
- we1  in  1  write enable, port W1
- wa1  in  ADDR_W  write address, port W1
- wd1  in  DATA_W  write data, port W1
- issue  in  1  mark register at issue_addr busy (instruction dispatched)
- issue_addr  in  ADDR_W  destination register being issued

Behaviour:
- Reset (rst_n=0, asynchronous): all registers clear to 0; all busy bits clear to 0. While reset is held, rd1, rd2, busy1 and busy2 all read 0. Writes and issues are ignored until the first rising edge after rst_n rises.
- Register 0 is hardwired to zero:
  - Writes to address 0 are discarded.
  - issue to address 0 is ignored.
  - Reading address 0 returns 0 with busy=0.
- Reads are combinational with zero latency: rd1 = reg[ra1], rd2 = reg[ra2].
- Writes take effect on the rising clk edge when the port's enable is 1 and its address is nonzero.
- W0 and W1 to the same nonzero address in the same cycle: W1 wins (load data overrides ALU data).
- Busy scoreboard, per register, updated on the rising edge:
  - Clear: a write on either port to address a clears busy[a].
  - Set: issue=1 sets busy[issue_addr].
  - Set and clear to the same address in the same cycle: set wins. The old producer retires and the new producer is pending.
  - Set on an already-busy register keeps it busy. There is no counting and no error flag.
- busy1 = busy[ra1], busy2 = busy[ra2]; combinational, reflecting the current state (pre-edge).
- Writes to a non-busy register are legal and do not change the busy bit.
- Reset asserted mid-operation clears everything immediately, including pending busy bits; in-flight writes are lost.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Same-cycle forwarding: if we1 && wa1==ra1 && ra1!=0, then rd1=wd1; else if we0 && wa0==ra1 && ra1!=0, then rd1=wd0; else rd1=reg[ra1]. rd2 follows the same rule.
  - busy1/busy2 read 0 when a write to that address is present in the current cycle, unless issue targets the same address this cycle.
- Not defined: reads return stored contents only; a write is visible from the cycle after the edge. busy reflects stored state only.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse rst_n low mid-cycle -> rd1 at ra1=5 reads 0 immediately and busy1=0; r0 reads 0 throughout.
- Zero register: we0=1, wa0=0, wd0=0x12345678, and issue to 0 -> ra1=0 gives rd1=0 and busy1=0 on every following cycle.
- Dual-write conflict: we0=1 and we1=1, both to r7, wd0=0x11, wd1=0x22 -> r7=0x22 after the edge; the same bench with distinct addresses r3/r4 gives r3=0x11, r4=0x22.
- Scoreboard: issue r9, then hold 3 cycles -> busy1(ra1=9)=1. W0 write r9 0xAB -> next cycle busy1=0 and rd1=0xAB. Issue r9 and W1 write r9 in the same cycle -> busy stays 1.
- Bypass, with REGFILE_BYPASS_EN defined: r10=0x5 stored, we0 to r10 with wd0=0x99 and ra2=10 -> rd2=0x99 in the same cycle. Without the macro, rd2=0x5 that cycle and 0x99 the next.
- Parameter sweep: DATA_W=16, NREGS=8 -> write/read all 7 nonzero registers with pattern 0xA5A0+i and check the readback; r0=0.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-ported register file: two write ports (W1 wins on conflict), two combinational reads,
// per-register busy scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 32,
    localparam int unsigned ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;

    // W1 is applied after W0 so load data overrides ALU data on an address conflict.
    always_comb begin
        regs_d = regs_q;
        if (we0) begin
            regs_d[wa0] = wd0;
        end
        if (we1) begin
            regs_d[wa1] = wd1;
        end
        regs_d[0] = '0;
    end

    // Clears first, then the issue set, so a new producer outranks a retiring one.
    always_comb begin
        busy_d = busy_q;
        if (we0) begin
            busy_d[wa0] = 1'b0;
        end
        if (we1) begin
            busy_d[wa1] = 1'b0;
        end
        if (issue) begin
            busy_d[issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd1   = regs_q[ra1];
        rd2   = regs_q[ra2];
        busy1 = busy_q[ra1];
        busy2 = busy_q[ra2];
`ifdef REGFILE_BYPASS_EN
        // Forwarding is suppressed while reset is held so outputs stay at zero.
        if (rst_n && ra1 != '0) begin
            if (we1 && wa1 == ra1) begin
                rd1 = wd1;
            end else if (we0 && wa0 == ra1) begin
                rd1 = wd0;
            end
            if (((we0 && wa0 == ra1) || (we1 && wa1 == ra1)) && !(issue && issue_addr == ra1)) begin
                busy1 = 1'b0;
            end
        end
        if (rst_n && ra2 != '0) begin
            if (we1 && wa1 == ra2) begin
                rd2 = wd1;
            end else if (we0 && wa0 == ra2) begin
                rd2 = wd0;
            end
            if (((we0 && wa0 == ra2) || (we1 && wa1 == ra2)) && !(issue && issue_addr == ra2)) begin
                busy2 = 1'b0;
            end
        end
`endif
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed table, reset/bypass sequences,
// randomized traffic against an array-based reference model, and a 16x8 parameter instance.
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa0, wa1, issue_addr;
    logic [31:0] rd1, rd2, wd0, wd1;
    logic        busy1, busy2, we0, we1, issue;

    logic [2:0]  s_ra1, s_ra2, s_wa0, s_wa1, s_ia;
    logic [15:0] s_rd1, s_rd2, s_wd0, s_wd1;
    logic        s_busy1, s_busy2, s_we0, s_we1, s_issue;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [32];
    bit          bsy [32];

    always #5 clk = ~clk;

    regfile_mp_sb dut (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2), .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .issue(issue), .issue_addr(issue_addr)
    );

    regfile_mp_sb #(.DATA_W(16), .NREGS(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .ra1(s_ra1), .ra2(s_ra2), .rd1(s_rd1), .rd2(s_rd2),
        .busy1(s_busy1), .busy2(s_busy2), .we0(s_we0), .wa0(s_wa0), .wd0(s_wd0),
        .we1(s_we1), .wa1(s_wa1), .wd1(s_wd1), .issue(s_issue), .issue_addr(s_ia)
    );

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iss;
        logic [4:0]  ia;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            bsy[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0 || !rst_n) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
`endif
        return mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0 || !rst_n) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (((we0 && wa0 == a) || (we1 && wa1 == a)) && !(issue && issue_addr == a)) return 1'b0;
`endif
        return bsy[a];
    endfunction

    task automatic idle();
        we0 = 0; we1 = 0; issue = 0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; issue_addr = '0;
    endtask

    // One clock: the model commits the inputs that are visible at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (we0 && wa0 != 0) mem[wa0] = wd0;
            if (we1 && wa1 != 0) mem[wa1] = wd1;
            if (we0) bsy[wa0] = 1'b0;
            if (we1) bsy[wa1] = 1'b0;
            if (issue && issue_addr != 0) bsy[issue_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".rd1"}, rd1, exp_rd(ra1));
        chk({tag, ".rd2"}, rd2, exp_rd(ra2));
        chk({tag, ".busy1"}, {31'b0, busy1}, {31'b0, exp_busy(ra1)});
        chk({tag, ".busy2"}, {31'b0, busy2}, {31'b0, exp_busy(ra2)});
    endtask

    initial begin
        // Zero reg, dual-write conflict, scoreboard set/clear/hold, set-wins, non-busy write.
        tbl[0]  = '{1, 0, 32'h12345678, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0};
        tbl[1]  = '{1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 0, 32'h22, 32'h0, 0, 0};
        tbl[2]  = '{1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 3, 4, 32'h11, 32'h22, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 1, 9, 9, 7, 32'h0, 32'h22, 1, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 7, 32'h0, 32'h22, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 32'h0, 32'h0, 1, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 32'h0, 32'h0, 1, 0};
        tbl[7]  = '{1, 9, 32'hAB, 0, 0, 0, 0, 0, 9, 0, 32'hAB, 32'h0, 0, 0};
        tbl[8]  = '{0, 0, 0, 1, 9, 32'hCD, 1, 9, 9, 0, 32'hCD, 32'h0, 1, 0};
        tbl[9]  = '{1, 3, 32'h33, 0, 0, 0, 1, 5, 5, 3, 32'h0, 32'h33, 1, 0};
        tbl[10] = '{0, 0, 0, 1, 5, 32'h55, 1, 3, 5, 3, 32'h55, 32'h33, 0, 1};
        tbl[11] = '{1, 4, 32'h44, 0, 0, 0, 0, 0, 4, 3, 32'h44, 32'h33, 0, 1};

        idle();
        ra1 = 5; ra2 = 0;
        s_we0 = 0; s_we1 = 0; s_issue = 0; s_wa0 = '0; s_wa1 = '0; s_ia = '0;
        s_wd0 = '0; s_wd1 = '0; s_ra1 = '0; s_ra2 = '0;
        model_clear();
        rst_n = 0;
        #2;
        chk("reset.rd1", rd1, 32'h0);
        chk("reset.busy1", {31'b0, busy1}, 32'h0);
        #20;
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
            we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
            issue = tbl[i].iss; issue_addr = tbl[i].ia;
            ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
            tick();
            idle();
            #2;
            chk($sformatf("tbl%0d.rd1", i), rd1, tbl[i].e_rd1);
            chk($sformatf("tbl%0d.rd2", i), rd2, tbl[i].e_rd2);
            chk($sformatf("tbl%0d.busy1", i), {31'b0, busy1}, {31'b0, tbl[i].e_b1});
            chk($sformatf("tbl%0d.busy2", i), {31'b0, busy2}, {31'b0, tbl[i].e_b2});
        end

        // Same-cycle visibility of a write on the read port.
        we0 = 1; wa0 = 10; wd0 = 32'h5;
        tick();
        idle();
        we0 = 1; wa0 = 10; wd0 = 32'h99; ra2 = 10; ra1 = 0;
        #2;
`ifdef REGFILE_BYPASS_EN
        chk("bypass.same", rd2, 32'h99);
`else
        chk("bypass.same", rd2, 32'h5);
`endif
        chk("bypass.r0", rd1, 32'h0);
        tick();
        idle();
        #2;
        chk("bypass.next", rd2, 32'h99);

        // Mid-cycle asynchronous reset wipes data and pending busy bits.
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; issue = 1; issue_addr = 6;
        tick();
        idle();
        ra1 = 5; ra2 = 6;
        #1;
        chk("prerst.rd1", rd1, 32'hDEADBEEF);
        chk("prerst.busy2", {31'b0, busy2}, 32'h1);
        rst_n = 0;
        model_clear();
        #1;
        chk("midrst.rd1", rd1, 32'h0);
        chk("midrst.busy1", {31'b0, busy1}, 32'h0);
        chk("midrst.busy2", {31'b0, busy2}, 32'h0);
        // Writes and issues during reset must be ignored.
        we1 = 1; wa1 = 5; wd1 = 32'hCAFE; issue = 1; issue_addr = 5;
        tick();
        chk("inrst.rd1", rd1, 32'h0);
        chk("inrst.busy1", {31'b0, busy1}, 32'h0);
        idle();
        #2;
        rst_n = 1;
        tick();
        #1;
        chk("postrst.rd1", rd1, 32'h0);
        chk("postrst.busy2", {31'b0, busy2}, 32'h0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 2) == 0);
            issue = 1'($urandom_range(0, 2) == 0);
            wa0 = 5'($urandom_range(0, 31));
            wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
            issue_addr = ($urandom_range(0, 3) == 0) ? wa1 : 5'($urandom_range(0, 31));
            wd0 = $urandom;
            wd1 = $urandom;
            ra1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? issue_addr : 5'($urandom_range(0, 31));
            @(negedge clk);
            chk_model($sformatf("rnd%0d", n));
            tick();
        end
        idle();

        // Narrow instance: 16-bit data, 8 registers.
        for (int i = 1; i < 8; i++) begin
            s_we0 = 1; s_wa0 = 3'(i); s_wd0 = 16'hA5A0 + 16'(i);
            @(posedge clk);
            #1;
        end
        s_we0 = 0;
        for (int i = 1; i < 8; i++) begin
            s_ra1 = 3'(i); s_ra2 = 3'(0);
            #2;
            chk($sformatf("narrow.r%0d", i), {16'b0, s_rd1}, 32'hA5A0 + 32'(i));
            chk("narrow.r0", {16'b0, s_rd2}, 32'h0);
            chk("narrow.busy1", {31'b0, s_busy1}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
